// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single registered memory port.
// Optional MEM_TIMEOUT_EN: abort a BUSY access after TIMEOUT_CYC cycles with err.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,

    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,

    output logic                grant_d,
    output logic                busy,
    output logic                err
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                grant_d_q, grant_d_d;
    logic                m_we_q, m_we_d;
    logic [BE_W-1:0]     m_be_q, m_be_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [SW-1:0]       starve_q, starve_d;

    logic                any_req;
    logic                pick_d;
    logic                grant_fire;
    logic                xfer_end;
    logic                timeout_fire;
    logic [DATA_W-1:0]   resp_word;

    assign any_req    = i_req | d_req;
    // D wins unless fetch is waiting and D has already had STARVE_MAX grants in a row
    assign pick_d     = d_req & (~i_req | (starve_q < SW'(STARVE_MAX)));
    assign grant_fire = (state_q == S_IDLE) & any_req;
    assign xfer_end   = (state_q == S_BUSY) & (m_ready | timeout_fire);

`ifdef MEM_TIMEOUT_EN
    localparam int                TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_W-1:0] TMO_WORD = DATA_W'(32'hDEADBEEF);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;

    assign timeout_fire = (state_q == S_BUSY) & ~m_ready &
                          (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign resp_word    = timeout_fire ? TMO_WORD : m_rdata;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
        if (grant_fire)
            tmo_cnt_d = '0;
        else if (state_q == S_BUSY)
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (xfer_end)
            err_d = timeout_fire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign resp_word    = m_rdata;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_BUSY;
            S_BUSY:  if (m_ready || timeout_fire) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; m_req is high exactly while BUSY, so it is still a registered signal
    always_comb begin
        m_req   = (state_q == S_BUSY);
        busy    = (state_q != S_IDLE);
        i_ready = (state_q == S_DONE) & ~grant_d_q;
        d_ready = (state_q == S_DONE) &  grant_d_q;
`ifdef MEM_TIMEOUT_EN
        err     = (state_q == S_DONE) & err_q;
`else
        err     = 1'b0;
`endif
    end

    // Request capture, starvation tracking and response capture
    always_comb begin
        grant_d_d = grant_d_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        starve_d  = starve_q;

        if (grant_fire) begin
            grant_d_d = pick_d;
            m_we_d    = pick_d & d_we;
            m_be_d    = pick_d ? d_be    : '1;
            m_addr_d  = pick_d ? d_addr  : i_addr;
            m_wdata_d = pick_d ? d_wdata : '0;
            if (pick_d && i_req) begin
                if (starve_q < SW'(STARVE_MAX))
                    starve_d = starve_q + SW'(1);
            end else begin
                starve_d = '0;
            end
        end

        if (xfer_end) begin
            if (!grant_d_q)
                i_rdata_d = resp_word;
            else if (!m_we_q)
                d_rdata_d = resp_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_d_q <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            starve_q  <= '0;
        end else begin
            grant_d_q <= grant_d_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            starve_q  <= starve_d;
        end
    end

    assign grant_d = grant_d_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scoreboard of expected read data per side, memory responder
// with programmable latency, grant-order log. Build with MEM_TIMEOUT_EN to add the timeout test.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        grant_d;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .grant_d(grant_d), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_i[$];
    exp_t        exp_d[$];
    logic        gnt_log[$];
    logic [31:0] model_d_rdata = 32'h0;
    int          mem_lat  = 0;
    logic        mem_en   = 1'b1;
    logic        spurious = 1'b0;
    int          busy_cnt = 0;
    logic        m_req_prev = 1'b0;
    int          ready_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h3C01_1234;
        return a ^ 32'hA5C3_0F1E;
    endfunction

    // Memory responder plus ready-pulse scoreboard, all on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            busy_cnt   = 0;
            m_ready    = 1'b0;
            m_rdata    = 32'h0;
            m_req_prev = 1'b0;
        end else begin
            if (m_req && !m_req_prev) gnt_log.push_back(grant_d);
            m_req_prev = m_req;

            if (i_ready) begin
                ready_cnt++;
                checks++;
                if (exp_i.size() == 0) begin
                    errors++;
                    $display("FAIL i_ready_unexpected: got pulse, required none");
                end else begin
                    e = exp_i.pop_front();
                    if (i_rdata !== e.rdata || err !== e.err) begin
                        errors++;
                        $display("FAIL i_resp: got rdata=%h err=%b, required rdata=%h err=%b",
                                 i_rdata, err, e.rdata, e.err);
                    end
                end
            end
            if (d_ready) begin
                ready_cnt++;
                checks++;
                if (exp_d.size() == 0) begin
                    errors++;
                    $display("FAIL d_ready_unexpected: got pulse, required none");
                end else begin
                    e = exp_d.pop_front();
                    if (d_rdata !== e.rdata || err !== e.err) begin
                        errors++;
                        $display("FAIL d_resp: got rdata=%h err=%b, required rdata=%h err=%b",
                                 d_rdata, err, e.rdata, e.err);
                    end
                end
            end

            if (m_req && mem_en && busy_cnt == mem_lat) begin
                m_ready = 1'b1;
                m_rdata = mem_word(m_addr);
            end else begin
                m_ready = spurious;
                m_rdata = 32'h0BAD_F00D;
            end
            if (m_req) busy_cnt++;
            else       busy_cnt = 0;
        end
    end

    task automatic i_xact(input logic [31:0] addr, input logic tmo,
                          output int t_mreq, output int t_rdy);
        exp_t e;
        int   n;
        @(negedge clk);
        i_req   = 1'b1;
        i_addr  = addr;
        e.rdata = tmo ? 32'hDEADBEEF : mem_word(addr);
        e.err   = tmo;
        exp_i.push_back(e);
        t_mreq = -1;
        t_rdy  = -1;
        n      = 0;
        while (t_rdy < 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (t_mreq < 0 && m_req && !grant_d) t_mreq = n;
            if (i_ready) t_rdy = n;
        end
        i_req = 1'b0;
    endtask

    task automatic d_xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output int t_rdy);
        exp_t e;
        int   n;
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = we;
        d_be    = be;
        d_addr  = addr;
        d_wdata = wdata;
        if (!we) model_d_rdata = mem_word(addr);
        e.rdata = model_d_rdata;
        e.err   = 1'b0;
        exp_d.push_back(e);
        t_rdy = -1;
        n     = 0;
        while (t_rdy < 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (d_ready) t_rdy = n;
        end
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        int rc;
        rst = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_req, m_we, i_ready, d_ready, grant_d, busy, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {m_req, m_we, i_ready, d_ready, grant_d, busy, err});
        end
        checks++;
        if (m_be !== 4'h0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mport: got be=%h addr=%h wdata=%h, required all 0",
                     m_be, m_addr, m_wdata);
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got i=%h d=%h, required 0", i_rdata, d_rdata);
        end
        rst = 1'b1;
        rc = ready_cnt;
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        spurious = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_req !== 1'b0 || ready_cnt != rc) begin
            errors++;
            $display("FAIL idle_mready_ignored: got busy=%b m_req=%b pulses=%0d, required 0 0 0",
                     busy, m_req, ready_cnt - rc);
        end
    endtask

    task automatic test_single_fetch();
        int tm, tr;
        mem_lat = 0;
        i_xact(32'h0040_0000, 1'b0, tm, tr);
        checks++;
        if (tm != 1 || tr != 2) begin
            errors++;
            $display("FAIL fetch_latency: got m_req@%0d ready@%0d, required 1 and 2", tm, tr);
        end
        checks++;
        if (m_addr !== 32'h0040_0000 || m_be !== 4'hF || m_we !== 1'b0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_mport: got addr=%h be=%h we=%b wdata=%h, required 00400000 f 0 0",
                     m_addr, m_be, m_we, m_wdata);
        end
        checks++;
        if (grant_d !== 1'b0) begin
            errors++;
            $display("FAIL fetch_grant: got grant_d=%b, required 0", grant_d);
        end
    endtask

    task automatic test_simultaneous();
        gnt_log.delete();
        mem_lat = 1;
        fork
            begin int t; d_xact(1'b0, 4'hF, 32'h1001_0000, 32'h0, t);
                checks++;
                if (t < 0) begin errors++; $display("FAIL simul_d_timeout: got none, required d_ready"); end
            end
            begin int tm, tr; i_xact(32'h0040_0004, 1'b0, tm, tr);
                checks++;
                if (tr < 0) begin errors++; $display("FAIL simul_i_timeout: got none, required i_ready"); end
            end
            begin
                repeat (2) @(negedge clk);
                checks++;
                if (m_req !== 1'b1 || grant_d !== 1'b1 || m_addr !== 32'h1001_0000 ||
                    dut.starve_q !== 3'd1) begin
                    errors++;
                    $display("FAIL simul_first: got m_req=%b grant_d=%b addr=%h starve=%0d, required 1 1 10010000 1",
                             m_req, grant_d, m_addr, dut.starve_q);
                end
            end
        join
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0] !== 1'b1 || gnt_log[1] !== 1'b0) begin
            errors++;
            $display("FAIL simul_order: got %0d grants first=%b, required D then I",
                     gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 1'bx);
        end
    endtask

    task automatic test_starvation();
        logic exp_g[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        gnt_log.delete();
        mem_lat = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    int t;
                    d_xact(1'b0, 4'hF, 32'h1001_0100 + 32'(4 * k), 32'h0, t);
                    checks++;
                    if (t < 0) begin errors++; $display("FAIL starve_d_timeout: xact %0d got none", k); end
                end
            end
            begin int tm, tr; i_xact(32'h0040_0100, 1'b0, tm, tr);
                checks++;
                if (tr < 0) begin errors++; $display("FAIL starve_i_timeout: got none, required i_ready"); end
            end
        join
        checks++;
        if (gnt_log.size() != 7) begin
            errors++;
            $display("FAIL starve_count: got %0d grants, required 7", gnt_log.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (gnt_log[k] !== exp_g[k]) begin
                    errors++;
                    $display("FAIL starve_order[%0d]: got grant_d=%b, required %b", k, gnt_log[k], exp_g[k]);
                end
            end
        end
    endtask

    task automatic test_store();
        mem_lat = 3;
        fork
            begin int t; d_xact(1'b1, 4'b0011, 32'h1001_0004, 32'hAABB_CCDD, t);
                checks++;
                if (t != 5) begin errors++; $display("FAIL store_latency: got ready@%0d, required 5", t); end
            end
            begin
                @(negedge clk);
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checks++;
                    if (m_req !== 1'b1 || m_we !== 1'b1 || m_be !== 4'b0011 ||
                        m_wdata !== 32'hAABB_CCDD || m_addr !== 32'h1001_0004) begin
                        errors++;
                        $display("FAIL store_hold[%0d]: got req=%b we=%b be=%b wdata=%h addr=%h, required 1 1 0011 aabbccdd 10010004",
                                 c, m_req, m_we, m_be, m_wdata, m_addr);
                    end
                end
            end
        join
    endtask

    task automatic test_reset_mid_busy();
        int rc, tm, tr;
        mem_lat = 10;
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = 32'h0040_0010;
        repeat (3) @(negedge clk);
        checks++;
        if (m_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got m_req=%b, required 1", m_req);
        end
        rc = ready_cnt;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({m_req, m_we, i_ready, d_ready, grant_d, busy, err} !== 7'b0 ||
            m_be !== 4'h0 || m_addr !== 32'h0 || m_wdata !== 32'h0 ||
            i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_async: got ctrl=%b be=%h addr=%h i_rd=%h d_rd=%h, required all 0",
                     {m_req, m_we, i_ready, d_ready, grant_d, busy, err}, m_be, m_addr, i_rdata, d_rdata);
        end
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (ready_cnt != rc || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_ready: got pulses=%0d busy=%b, required 0 0", ready_cnt - rc, busy);
        end
        mem_lat = 0;
        i_xact(32'h0040_0020, 1'b0, tm, tr);
        checks++;
        if (tm != 1 || tr != 2) begin
            errors++;
            $display("FAIL midrst_after: got m_req@%0d ready@%0d, required 1 and 2", tm, tr);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int tm, tr;
        mem_en = 1'b0;
        i_xact(32'h0040_0200, 1'b1, tm, tr);
        mem_en = 1'b1;
        checks++;
        if (tm != 1 || tr - tm != 8) begin
            errors++;
            $display("FAIL timeout_latency: got m_req@%0d ready@%0d, required 1 and 9", tm, tr);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: got err=%b busy=%b, required 0 0", err, busy);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_reset_mid_busy();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (exp_i.size() != 0 || exp_d.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d I and %0d D pending, required 0 0",
                     exp_i.size(), exp_d.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
